fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset; it SHALL equal the reset value of the PC register.
REQ-002 Parameter DEPTH, default 2, the number of fetch-buffer entries; it SHALL be a power of two and at least 2.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 PC  in  32  current program counter from the PC register.
REQ-006 PCNext  out  32  next PC fed back to the PC register.
REQ-007 imem_req  out  1  instruction-memory request valid.
REQ-008 imem_addr  out  32  request address (word-aligned).
REQ-009 imem_gnt  in  1  memory accepts the request this cycle.
REQ-010 imem_rvalid  in  1  response data valid.
REQ-011 imem_rdata  in  32  response instruction word.
REQ-012 redirect  in  1  branch/jump taken; flush and refetch.
REQ-013 redirect_pc  in  32  target address of the redirect.
REQ-014 if_valid  out  1  buffer head holds a valid instruction for decode.
REQ-015 if_instr  out  32  instruction at the buffer head.
REQ-016 if_pc  out  32  PC of the instruction at the buffer head.
REQ-017 id_ready  in  1  decode consumes the head when if_valid && id_ready.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT and DROP; at most one memory request is outstanding at any time.
REQ-019 IDLE->REQ when credit is available (buffer occupancy + outstanding < DEPTH) and redirect=0; otherwise stay in IDLE.
REQ-020 In REQ: imem_req=1 and imem_addr=PC; on imem_gnt go to WAIT. imem_req SHALL stay high and imem_addr stable until gnt.
REQ-021 PCNext SHALL be PC+4 on the cycle of an accepted request, redirect_pc when redirect=1, and PC otherwise (hold).
REQ-022 In WAIT, on imem_rvalid write {PC-of-request, imem_rdata} to the buffer tail, then go to REQ if credit remains, else IDLE.
REQ-023 If redirect=1 in WAIT, or in REQ together with imem_gnt, go to DROP; the matching response SHALL be discarded. DROP->IDLE on imem_rvalid.
REQ-024 If redirect=1 in REQ without gnt, the request SHALL be withdrawn next cycle and the state SHALL return to IDLE.
REQ-025 Redirect SHALL clear the buffer in the same edge; if_valid=0 the following cycle. Redirect has priority over a simultaneous rvalid write and id_ready pop.
REQ-026 The buffer SHALL be a FIFO with wrap-around pointers; a push and a pop in the same cycle when full or when empty+bypass-free SHALL both take effect, with no bypass from imem_rdata to if_instr.
REQ-027 A push when full SHALL never occur (guaranteed by credit); an assertion flags it.
REQ-028 PC+4 SHALL wrap modulo 2^32.

Reset
REQ-029 On reset: state=IDLE, buffer empty, imem_req=0, if_valid=0, if_instr=0, if_pc=0, and PCNext=RESET_PC.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; any imem_rvalid in the first cycle after reset deassertion SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, XLEN=32, and the INSTR_NOP constant 32'h0000_0013.
REQ-032 The buffer SHALL be a sub-module, fetch_fifo (parameters DEPTH and width 64), with push, pop, flush, full, empty and count.

Verification
REQ-033 Reset released, gnt=1 always, rvalid one cycle after gnt, id_ready=1 -> if_pc sequence 0,4,8,C; first if_valid 3 cycles after reset deassertion.
REQ-034 id_ready=0 -> exactly DEPTH instructions are buffered, imem_req drops to 0, PC holds at 8.
REQ-035 gnt held low for 5 cycles -> imem_req stays 1 and imem_addr stays constant; PCNext=PC throughout.
REQ-036 redirect to 32'h100 while in WAIT -> the stale response is dropped, the buffer is empty, and the next if_pc=32'h100.
REQ-037 Redirect together with rvalid and id_ready in the same cycle -> nothing is enqueued, PCNext=redirect_pc.
REQ-038 Reset asserted in WAIT, then rvalid arrives -> no instruction is enqueued, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two FIFO with wrap-around pointers, synchronous flush,
// no bypass from write data to the head.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop on empty is ignored; a push on full only lands if the head leaves this cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (AW + 1)'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    push_while_full_a : assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop && !flush))
        else $error("fetch_fifo: push while full");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, credit-limited by the
// fetch buffer, with redirect flush and stale-response dropping.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCNext,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [XLEN-1:0]   pc_next;
    logic              push, pop, full, empty;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;

    assign pop = ~empty & id_ready & ~redirect;

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        pc_next  = PC;
        imem_req = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect && !full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    req_pc_d = PC;
                    pc_next  = PC + 32'd4;
                    state_d  = redirect ? DROP : WAIT;
                end else if (redirect) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // A response arriving with the redirect is the one being dropped.
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = (pop || count < CW'(DEPTH - 1)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            pc_next = redirect_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign PCNext    = reset ? RESET_PC : pc_next;
    assign imem_addr = {PC[XLEN-1:2], 2'b00};
    assign if_valid  = ~empty;
    assign if_pc     = empty ? '0 : head[2*XLEN-1:XLEN];
    assign if_instr  = empty ? '0 : head[XLEN-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule
